// File: rtl/regfile_mp.sv
`default_nettype none
// ============================================================================
// Module   : regfile_mp
// Brief    : Parametrised multi-port register file with a command port, an
//            independent ALU write-back port and a hardware stack pointer.
//            Define REGFILE_MP_BYPASS_EN to forward same-cycle ALU writes to
//            reads and operand outputs.
// Revision : 1.0 - initial release
// ============================================================================
module regfile_mp #(
    parameter int                  DATA_WIDTH  = 16,
    parameter int                  REGISTERS   = 8,
    parameter int                  INDEX_WIDTH = $clog2(REGISTERS),
    parameter int                  SP_INDEX    = REGISTERS - 2,
    parameter int                  F_INDEX     = REGISTERS - 1,
    parameter logic [DATA_WIDTH-1:0] SP_RESET  = {DATA_WIDTH{1'b1}},
    parameter int                  SP_STEP     = 1
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   cmd_valid,
    input  logic [3:0]             cmd,
    input  logic [DATA_WIDTH-1:0]  cmd_data,
    input  logic                   alu_we,
    input  logic [1:0]             alu_wsel,
    input  logic [DATA_WIDTH-1:0]  alu_result,
    input  logic [DATA_WIDTH-1:0]  alu_flags,
    output logic [INDEX_WIDTH-1:0] sel_a,
    output logic [INDEX_WIDTH-1:0] sel_b,
    output logic [INDEX_WIDTH-1:0] sel_c,
    output logic [DATA_WIDTH-1:0]  op_a,
    output logic [DATA_WIDTH-1:0]  op_b,
    output logic                   rd_valid,
    output logic [DATA_WIDTH-1:0]  rd_data,
    output logic [DATA_WIDTH-1:0]  sp,
    output logic                   sp_ovf
);

    localparam logic [3:0] c_CMD_NOP      = 4'd0;
    localparam logic [3:0] c_CMD_READA    = 4'd1;
    localparam logic [3:0] c_CMD_READB    = 4'd2;
    localparam logic [3:0] c_CMD_LATCHC   = 4'd3;
    localparam logic [3:0] c_CMD_LATCHSEL = 4'd4;
    localparam logic [3:0] c_CMD_READF    = 4'd5;
    localparam logic [3:0] c_CMD_ALU_WE   = 4'd6;
    localparam logic [3:0] c_CMD_SP_WE    = 4'd7;
    localparam logic [3:0] c_CMD_PUSH     = 4'd8;
    localparam logic [3:0] c_CMD_POP      = 4'd9;

    localparam logic [INDEX_WIDTH-1:0] c_SP_IDX = INDEX_WIDTH'(SP_INDEX);
    localparam logic [INDEX_WIDTH-1:0] c_F_IDX  = INDEX_WIDTH'(F_INDEX);
    localparam logic [DATA_WIDTH:0]    c_STEP   = (DATA_WIDTH+1)'(SP_STEP);

    logic [DATA_WIDTH-1:0]  regs_q [REGISTERS];
    logic [DATA_WIDTH-1:0]  regs_d [REGISTERS];
    logic [INDEX_WIDTH-1:0] sel_a_q, sel_a_d;
    logic [INDEX_WIDTH-1:0] sel_b_q, sel_b_d;
    logic [INDEX_WIDTH-1:0] sel_c_q, sel_c_d;
    logic                   rd_valid_q, rd_valid_d;
    logic [DATA_WIDTH-1:0]  rd_data_q, rd_data_d;
    logic                   sp_ovf_q, sp_ovf_d;
    logic [DATA_WIDTH:0]    w_sp_dec;
    logic [DATA_WIDTH:0]    w_sp_inc;

    // Extra top bit captures the borrow / carry of the stack-pointer step.
    assign w_sp_dec = {1'b0, regs_q[SP_INDEX]} - c_STEP;
    assign w_sp_inc = {1'b0, regs_q[SP_INDEX]} + c_STEP;

    // Read value of a register as seen by same-cycle readers.
    function automatic logic [DATA_WIDTH-1:0] f_read(input logic [INDEX_WIDTH-1:0] idx);
        logic [DATA_WIDTH-1:0] v;
        v = regs_q[idx];
`ifdef REGFILE_MP_BYPASS_EN
        if (alu_we && alu_wsel[0] && (idx == sel_c_q)) v = alu_result;
        if (alu_we && alu_wsel[1] && (idx == c_F_IDX)) v = alu_flags;
`endif
        if (idx == '0) v = '0;
        return v;
    endfunction

    always_comb begin
        op_a = f_read(sel_a_q);
        op_b = f_read(sel_b_q);
    end

    always_comb begin
        regs_d     = regs_q;
        sel_a_d    = sel_a_q;
        sel_b_d    = sel_b_q;
        sel_c_d    = sel_c_q;
        rd_valid_d = 1'b0;
        rd_data_d  = rd_data_q;
        sp_ovf_d   = sp_ovf_q;

        // ALU writes first so that a colliding command write overrides them.
        if (alu_we) begin
            if (alu_wsel[0] && (sel_c_q != '0)) regs_d[sel_c_q] = alu_result;
            if (alu_wsel[1])                    regs_d[F_INDEX] = alu_flags;
        end

        if (cmd_valid) begin
            case (cmd)
                c_CMD_READA: begin
                    rd_valid_d = 1'b1;
                    rd_data_d  = f_read(sel_a_q);
                end
                c_CMD_READB: begin
                    rd_valid_d = 1'b1;
                    rd_data_d  = f_read(sel_b_q);
                end
                c_CMD_READF: begin
                    rd_valid_d = 1'b1;
                    rd_data_d  = f_read(c_F_IDX);
                end
                c_CMD_LATCHC: begin
                    if (sel_c_q != '0) regs_d[sel_c_q] = cmd_data;
                end
                c_CMD_LATCHSEL: begin
                    sel_a_d = cmd_data[INDEX_WIDTH-1:0];
                    sel_b_d = cmd_data[2*INDEX_WIDTH-1:INDEX_WIDTH];
                    sel_c_d = cmd_data[3*INDEX_WIDTH-1:2*INDEX_WIDTH];
                end
                c_CMD_SP_WE: begin
                    regs_d[SP_INDEX] = cmd_data;
                    sp_ovf_d         = 1'b0;
                end
                c_CMD_PUSH: begin
                    regs_d[SP_INDEX] = w_sp_dec[DATA_WIDTH-1:0];
                    if (w_sp_dec[DATA_WIDTH]) sp_ovf_d = 1'b1;
                end
                c_CMD_POP: begin
                    regs_d[SP_INDEX] = w_sp_inc[DATA_WIDTH-1:0];
                    if (w_sp_inc[DATA_WIDTH]) sp_ovf_d = 1'b1;
                end
                c_CMD_NOP, c_CMD_ALU_WE: ;
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < REGISTERS; i++) begin
                regs_q[i] <= (i == SP_INDEX) ? SP_RESET : '0;
            end
            sel_a_q    <= '0;
            sel_b_q    <= '0;
            sel_c_q    <= '0;
            rd_valid_q <= 1'b0;
            rd_data_q  <= '0;
            sp_ovf_q   <= 1'b0;
        end else begin
            regs_q     <= regs_d;
            sel_a_q    <= sel_a_d;
            sel_b_q    <= sel_b_d;
            sel_c_q    <= sel_c_d;
            rd_valid_q <= rd_valid_d;
            rd_data_q  <= rd_data_d;
            sp_ovf_q   <= sp_ovf_d;
        end
    end

    assign sel_a    = sel_a_q;
    assign sel_b    = sel_b_q;
    assign sel_c    = sel_c_q;
    assign rd_valid = rd_valid_q;
    assign rd_data  = rd_data_q;
    assign sp       = regs_q[SP_INDEX];
    assign sp_ovf   = sp_ovf_q;

endmodule
`default_nettype wire

// File: tb/tb_regfile_mp.sv
`default_nettype none
// ============================================================================
// Module   : tb_regfile_mp
// Brief    : Directed self-checking bench for regfile_mp (default parameters).
// Revision : 1.0 - initial release
// ============================================================================
module tb_regfile_mp;

    logic        clk;
    logic        reset;
    logic        cmd_valid;
    logic [3:0]  cmd;
    logic [15:0] cmd_data;
    logic        alu_we;
    logic [1:0]  alu_wsel;
    logic [15:0] alu_result;
    logic [15:0] alu_flags;
    logic [2:0]  sel_a, sel_b, sel_c;
    logic [15:0] op_a, op_b;
    logic        rd_valid;
    logic [15:0] rd_data;
    logic [15:0] sp;
    logic        sp_ovf;

    int n_cmp;
    int n_err;

    regfile_mp dut (
        .clk        (clk),
        .reset      (reset),
        .cmd_valid  (cmd_valid),
        .cmd        (cmd),
        .cmd_data   (cmd_data),
        .alu_we     (alu_we),
        .alu_wsel   (alu_wsel),
        .alu_result (alu_result),
        .alu_flags  (alu_flags),
        .sel_a      (sel_a),
        .sel_b      (sel_b),
        .sel_c      (sel_c),
        .op_a       (op_a),
        .op_b       (op_b),
        .rd_valid   (rd_valid),
        .rd_data    (rd_data),
        .sp         (sp),
        .sp_ovf     (sp_ovf)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Advance one clock edge; inputs are cleared after the edge so each step is one cycle.
    task automatic tick();
        @(posedge clk);
        #1;
        cmd_valid = 1'b0;
        cmd       = 4'd0;
        alu_we    = 1'b0;
        alu_wsel  = 2'b00;
    endtask

    task automatic do_cmd(input logic [3:0] c, input logic [15:0] d);
        cmd_valid = 1'b1;
        cmd       = c;
        cmd_data  = d;
        tick();
    endtask

    initial begin
        n_cmp      = 0;
        n_err      = 0;
        reset      = 1'b1;
        cmd_valid  = 1'b0;
        cmd        = 4'd0;
        cmd_data   = 16'h0;
        alu_we     = 1'b0;
        alu_wsel   = 2'b00;
        alu_result = 16'h0;
        alu_flags  = 16'h0;
        tick();
        tick();
        reset = 1'b0;

        chk("rst_sp",       sp,              16'hFFFF);
        chk("rst_ovf",      {15'b0, sp_ovf}, 16'h0);
        chk("rst_rdvalid",  {15'b0, rd_valid}, 16'h0);
        chk("rst_rddata",   rd_data,         16'h0);
        chk("rst_sels",     {7'b0, sel_c, sel_b, sel_a}, 16'h0);

        // READA of index 0
        do_cmd(4'd1, 16'h0);
        chk("reada0_valid", {15'b0, rd_valid}, 16'h1);
        chk("reada0_data",  rd_data,         16'h0);
        tick();
        chk("rdvalid_drop", {15'b0, rd_valid}, 16'h0);

        // LATCHSEL c=1 b=2 a=3
        do_cmd(4'd4, 16'h0053);
        chk("latchsel_a", {13'b0, sel_a}, 16'd3);
        chk("latchsel_b", {13'b0, sel_b}, 16'd2);
        chk("latchsel_c", {13'b0, sel_c}, 16'd1);

        do_cmd(4'd3, 16'hBEEF);
        do_cmd(4'd4, 16'h0051);
        chk("opa_reg1", op_a, 16'hBEEF);
        do_cmd(4'd1, 16'h0);
        chk("reada_reg1", rd_data, 16'hBEEF);
        tick();
        chk("rddata_hold", rd_data, 16'hBEEF);

        // write to index 0 is dropped
        do_cmd(4'd4, 16'h0011);
        do_cmd(4'd3, 16'h1234);
        do_cmd(4'd4, 16'h0010);
        do_cmd(4'd1, 16'h0);
        chk("read_idx0", rd_data, 16'h0);

        // stack pointer
        do_cmd(4'd7, 16'h0000);
        chk("spwe_sp", sp, 16'h0000);
        do_cmd(4'd8, 16'h0);
        chk("push_wrap_sp",  sp,              16'hFFFF);
        chk("push_wrap_ovf", {15'b0, sp_ovf}, 16'h1);
        do_cmd(4'd9, 16'h0);
        chk("pop_wrap_sp",   sp,              16'h0000);
        chk("pop_ovf_stick", {15'b0, sp_ovf}, 16'h1);
        do_cmd(4'd7, 16'h0010);
        chk("spwe_clr_ovf",  {15'b0, sp_ovf}, 16'h0);
        do_cmd(4'd8, 16'h0);
        chk("push_sp",       sp,              16'h000F);
        chk("push_no_ovf",   {15'b0, sp_ovf}, 16'h0);

        // LATCHC vs ALU C+F conflict, sel_c=2
        do_cmd(4'd4, 16'h0091);
        alu_we     = 1'b1;
        alu_wsel   = 2'b11;
        alu_result = 16'h2222;
        alu_flags  = 16'h0005;
        do_cmd(4'd3, 16'h1111);
        do_cmd(4'd4, 16'h00BA);
        chk("conflict_reg2", op_a, 16'h1111);
        chk("conflict_flag", op_b, 16'h0005);
        do_cmd(4'd5, 16'h0);
        chk("readf", rd_data, 16'h0005);

        // ALU write to SP, then PUSH colliding with ALU write
        do_cmd(4'd4, 16'h01BA);
        alu_we     = 1'b1;
        alu_wsel   = 2'b01;
        alu_result = 16'h5555;
        tick();
        chk("alu_sp",     sp,              16'h5555);
        chk("alu_sp_ovf", {15'b0, sp_ovf}, 16'h0);
        alu_we     = 1'b1;
        alu_wsel   = 2'b01;
        alu_result = 16'h7777;
        do_cmd(4'd8, 16'h0);
        chk("push_wins", sp, 16'h5554);

        // same-cycle ALU write and READA, sel_a=sel_c=4
        do_cmd(4'd4, 16'h013C);
        do_cmd(4'd3, 16'h0F0F);
        alu_we     = 1'b1;
        alu_wsel   = 2'b01;
        alu_result = 16'hA5A5;
        cmd_valid  = 1'b1;
        cmd        = 4'd1;
        #1;
`ifdef REGFILE_MP_BYPASS_EN
        chk("opa_bypass", op_a, 16'hA5A5);
`else
        chk("opa_bypass", op_a, 16'h0F0F);
`endif
        tick();
`ifdef REGFILE_MP_BYPASS_EN
        chk("reada_same", rd_data, 16'hA5A5);
`else
        chk("reada_same", rd_data, 16'h0F0F);
`endif
        do_cmd(4'd1, 16'h0);
        chk("reada_next", rd_data, 16'hA5A5);

        // reset with a PUSH and read pending
        do_cmd(4'd4, 16'h01FF);
        reset = 1'b1;
        do_cmd(4'd8, 16'h0);
        reset = 1'b0;
        chk("midrst_sp",   sp,              16'hFFFF);
        chk("midrst_sels", {7'b0, sel_c, sel_b, sel_a}, 16'h0);
        chk("midrst_ovf",  {15'b0, sp_ovf}, 16'h0);
        reset = 1'b1;
        do_cmd(4'd1, 16'h0);
        reset = 1'b0;
        chk("midrst_rdvalid", {15'b0, rd_valid}, 16'h0);
        chk("midrst_rddata",  rd_data,         16'h0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/regfile_mp.md
Name: regfile_mp

Overview:
- Parametrised successor to the 8×3-bit-index register file, generalised in data width and register count.
- Command-driven read/write port plus an independent ALU write-back port that can write in the same cycle.
- Hardware stack-pointer push/pop with a sticky over/underflow flag.
- Sits between the control sequencer (command port) and the ALU (write-back port, operand reads).

Parameters:
- DATA_WIDTH, 16: width of every register and data bus.
- REGISTERS, 8: register count, power of two, ≥4.
- INDEX_WIDTH, $clog2(REGISTERS): select width.
- SP_INDEX, REGISTERS-2: stack-pointer register index.
- F_INDEX, REGISTERS-1: flags register index.
- SP_RESET, {DATA_WIDTH{1'b1}}: SP value after reset.
- SP_STEP, 1: push/pop step, must be < 2^DATA_WIDTH.

Ports:
- clk, in, 1: clock. Single clock domain, rising-edge.
- reset, in, 1: synchronous, active-high reset.
- cmd_valid, in, 1: command strobe. Sampled every edge; no back-pressure.
- cmd, in, 4: command code.
- cmd_data, in, DATA_WIDTH: write data, or packed selects.
- alu_we, in, 1: ALU write-back strobe.
- alu_wsel, in, 2: 00 none, 01 reg C, 10 flags, 11 C and flags.
- alu_result, in, DATA_WIDTH: ALU result.
- alu_flags, in, DATA_WIDTH: ALU flags.
- sel_a, out, INDEX_WIDTH: latched select A.
- sel_b, out, INDEX_WIDTH: latched select B.
- sel_c, out, INDEX_WIDTH: latched select C.
- op_a, out, DATA_WIDTH: combinational value of reg[sel_a], 0 if sel_a==0.
- op_b, out, DATA_WIDTH: combinational value of reg[sel_b], 0 if sel_b==0.
- rd_valid, out, 1: one-cycle pulse marking rd_data valid.
- rd_data, out, DATA_WIDTH: registered read result.
- sp, out, DATA_WIDTH: current SP register.
- sp_ovf, out, 1: sticky stack over/underflow.

Behaviour:
- Reset (takes priority over all inputs):
  - all registers 0 except SP = SP_RESET.
  - sel_a/b/c = 0, rd_valid = 0, rd_data = 0, sp_ovf = 0.
  - A command or ALU write presented in a reset cycle is discarded.
- Register 0 always reads 0; any write to index 0 is dropped.
- Commands act only when cmd_valid=1. All effects land at the next rising edge.
  - 0 NOP: no effect.
  - 1 READA: rd_data ← reg[sel_a]; rd_valid=1 the following cycle (1-cycle latency).
  - 2 READB: as READA, using sel_b.
  - 3 LATCHC: reg[sel_c] ← cmd_data.
  - 4 LATCHSEL: {sel_c, sel_b, sel_a} ← cmd_data[3*INDEX_WIDTH-1:0]; remaining bits ignored.
  - 5 READF: rd_data ← reg[F_INDEX], 1-cycle latency.
  - 6 ALU_WE: no effect. Code kept for compatibility; the ALU port is now independent.
  - 7 SP_WE: SP ← cmd_data; sp_ovf ← 0.
  - 8 PUSH: SP ← SP − SP_STEP, modulo 2^DATA_WIDTH; sp_ovf ← 1 if the subtraction borrows.
  - 9 POP: SP ← SP + SP_STEP, modulo 2^DATA_WIDTH; sp_ovf ← 1 if the addition carries.
  - 10–15: treated as NOP.
- rd_valid is 0 on every cycle not following a read command. rd_data holds its last value when no read occurs.
- ALU port (when alu_we=1):
  - Writes reg[sel_c] and/or reg[F_INDEX] per alu_wsel.
  - sel_c used is the value before any same-cycle LATCHSEL takes effect.
- Write conflict: if the command port and ALU port target the same register in the same cycle, the command port wins. This covers LATCHC, SP_WE, PUSH and POP (SP) against the ALU's C or F target.
- ALU writes to SP_INDEX are legal and do not affect sp_ovf.
- sp_ovf clears only on reset or SP_WE.
- Reads in the cycle after a write return the new value. A same-cycle read of a register being written by the ALU port follows the Optional Feature.

Optional Feature:
- Macro: REGFILE_MP_BYPASS_EN.
- Defined:
  - A READA/READB/READF whose target receives an ALU write in the same cycle returns the ALU value in rd_data.
  - op_a/op_b forward alu_result/alu_flags combinationally when alu_we targets sel_a/sel_b.
- Undefined:
  - Same-cycle reads return the pre-write (old) value.
  - op_a/op_b reflect only stored state.

Test Plan:
- Reset then READA with sel_a=0 -> rd_valid=1 one cycle later, rd_data=0. sp=0xFFFF, sp_ovf=0.
- LATCHSEL cmd_data=0x0053 (c=1, b=2, a=3), then LATCHC 0xBEEF, then LATCHSEL a=1, then READA -> rd_data=0xBEEF. LATCHC with sel_c=0 then READ of index 0 -> 0.
- SP_WE 0x0000, PUSH -> sp=0xFFFF, sp_ovf=1. POP -> sp=0x0000, sp_ovf stays 1. SP_WE 0x0010 -> sp_ovf=0.
- sel_c=2, same cycle LATCHC 0x1111 and alu_we wsel=11 result 0x2222 flags 0x0005 -> reg2=0x1111, reg7=0x0005.
- sel_a=4, alu_we wsel=01 result 0xA5A5 with READA the same cycle -> rd_data=0xA5A5 with bypass, old value without. Next READA -> 0xA5A5 in both builds.
- Reset asserted mid-sequence with a PUSH pending -> sp=SP_RESET, all selects 0, rd_valid=0 on the following cycle.
